// File: rtl/rename_pkg.sv
// Shared types for the two-wide rename stage: per-slot request and renamed result.
package rename_pkg;
  localparam int AREG_W    = 5;
  localparam int PREG_W    = 6;
  localparam int NUM_LANES = 2;

  typedef logic [PREG_W-1:0] preg_t;
  typedef logic [AREG_W-1:0] areg_t;

  typedef struct packed {
    areg_t rs1;
    areg_t rs2;
    areg_t rd;
    logic  rd_write;
  } rename_req_t;

  typedef struct packed {
    preg_t prs1;
    preg_t prs2;
    preg_t prd;
    preg_t old_prd;
  } rename_out_t;
endpackage

// File: rtl/rename_stage_free_list.sv
// Circular physical-register free list: 2-wide speculative pop, 2-wide commit push,
// single-cycle rollback of the speculative head to the commit head.
module free_list #(
  parameter int PREG_W   = 6,
  parameter int FL_DEPTH = 32,
  localparam int PTR_W   = $clog2(FL_DEPTH) + 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   recover,
  input  logic [1:0]             pop_cnt,
  output logic [PREG_W-1:0]      head_prd_1,
  output logic [PREG_W-1:0]      head_prd_2,
  output logic [PTR_W-1:0]       free_cnt,
  input  logic [1:0]             push_en,
  input  logic [1:0][PREG_W-1:0] push_prd
);
  localparam int IW = PTR_W - 1;

  logic [FL_DEPTH-1:0][PREG_W-1:0] fl;
  logic [PTR_W-1:0] spec_head, commit_head, tail, commit_head_nxt;
  logic [1:0]       push_cnt;
  logic [IW-1:0]    head_idx, tail_idx;

  assign head_idx        = spec_head[IW-1:0];
  assign tail_idx        = tail[IW-1:0];
  assign push_cnt        = {1'b0, push_en[0]} + {1'b0, push_en[1]};
  assign commit_head_nxt = commit_head + PTR_W'(push_cnt);
  assign free_cnt        = tail - spec_head;
  assign head_prd_1      = fl[head_idx];
  assign head_prd_2      = fl[IW'(head_idx + IW'(1))];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < FL_DEPTH; i++)
        fl[i] <= PREG_W'((1 << PREG_W) - FL_DEPTH + i);
      spec_head   <= '0;
      commit_head <= '0;
      tail        <= PTR_W'(FL_DEPTH);
    end else begin
      // Slot 2's push lands behind slot 1's when both retire together.
      if (push_en[0]) fl[tail_idx] <= push_prd[0];
      if (push_en[1]) fl[IW'(tail_idx + IW'(push_en[0]))] <= push_prd[1];
      tail        <= tail + PTR_W'(push_cnt);
      commit_head <= commit_head_nxt;
      spec_head   <= recover ? commit_head_nxt : spec_head + PTR_W'(pop_cnt);
    end
  end

  always_ff @(posedge clk)
    if (!reset) assert (free_cnt <= PTR_W'(FL_DEPTH));
endmodule

// File: rtl/rename_stage.sv
// Two-wide register rename: speculative/architectural RATs, intra-group bypass,
// free-list allocation and a single registered output stage toward dispatch.
module rename_stage #(
  parameter int AREG_W   = 5,
  parameter int PREG_W   = 6,
  parameter int FL_DEPTH = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid_1,
  input  logic              in_valid_2,
  input  logic [AREG_W-1:0] rs1_1,
  input  logic [AREG_W-1:0] rs2_1,
  input  logic [AREG_W-1:0] rd_1,
  input  logic [AREG_W-1:0] rs1_2,
  input  logic [AREG_W-1:0] rs2_2,
  input  logic [AREG_W-1:0] rd_2,
  input  logic              rd_write_1,
  input  logic              rd_write_2,
  output logic              in_ready,
  output logic              out_valid_1,
  output logic              out_valid_2,
  output logic [PREG_W-1:0] prs1_1,
  output logic [PREG_W-1:0] prs2_1,
  output logic [PREG_W-1:0] prd_1,
  output logic [PREG_W-1:0] old_prd_1,
  output logic [PREG_W-1:0] prs1_2,
  output logic [PREG_W-1:0] prs2_2,
  output logic [PREG_W-1:0] prd_2,
  output logic [PREG_W-1:0] old_prd_2,
  input  logic              out_ready,
  input  logic              commit_en_1,
  input  logic              commit_en_2,
  input  logic [AREG_W-1:0] commit_rd_1,
  input  logic [AREG_W-1:0] commit_rd_2,
  input  logic [PREG_W-1:0] commit_prd_1,
  input  logic [PREG_W-1:0] commit_prd_2,
  input  logic [PREG_W-1:0] commit_old_prd_1,
  input  logic [PREG_W-1:0] commit_old_prd_2,
  input  logic              recover
);
  import rename_pkg::*;

  localparam int NUM_AREG = 1 << AREG_W;
  localparam int PTR_W    = $clog2(FL_DEPTH) + 1;

  rename_req_t [NUM_LANES-1:0]              req;
  rename_out_t [NUM_LANES-1:0]              ren, out_q;
  logic        [NUM_LANES-1:0]              vin, need, out_vld;
  logic        [NUM_LANES-1:0][PREG_W-1:0]  fl_head, new_prd;
  logic        [NUM_AREG-1:0][PREG_W-1:0]   spec_rat, arch_rat, arch_nxt;
  logic [1:0]       need_cnt, pop_cnt;
  logic [PTR_W-1:0] free_cnt;
  logic             accept;

  assign req[0] = {rs1_1, rs2_1, rd_1, rd_write_1};
  assign req[1] = {rs1_2, rs2_2, rd_2, rd_write_2};
  assign vin    = {in_valid_2, in_valid_1};

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_need
    assign need[l] = vin[l] && req[l].rd_write && (req[l].rd != '0);
  end

  assign need_cnt = {1'b0, need[0]} + {1'b0, need[1]};
  assign in_ready = !recover && (!out_vld[0] || out_ready) && (free_cnt >= PTR_W'(need_cnt));
  assign accept   = in_valid_1 && in_ready;
  assign pop_cnt  = accept ? need_cnt : 2'd0;

  // Slot 2 takes the head entry when slot 1 allocates nothing.
  assign new_prd[0] = need[0] ? fl_head[0] : '0;
  assign new_prd[1] = !need[1] ? '0 : need[0] ? fl_head[1] : fl_head[0];

  always_comb begin
    ren = '0;
    ren[0].prs1    = spec_rat[req[0].rs1];
    ren[0].prs2    = spec_rat[req[0].rs2];
    ren[0].prd     = new_prd[0];
    ren[0].old_prd = need[0] ? spec_rat[req[0].rd] : '0;
    ren[1].prs1    = (need[0] && req[1].rs1 == req[0].rd) ? new_prd[0] : spec_rat[req[1].rs1];
    ren[1].prs2    = (need[0] && req[1].rs2 == req[0].rd) ? new_prd[0] : spec_rat[req[1].rs2];
    ren[1].prd     = new_prd[1];
    ren[1].old_prd = !need[1] ? '0 :
                     (need[0] && req[1].rd == req[0].rd) ? new_prd[0] : spec_rat[req[1].rd];
  end

  // Committed view including this cycle's retirements; recover copies it wholesale.
  always_comb begin
    arch_nxt = arch_rat;
    if (commit_en_1 && commit_rd_1 != '0) arch_nxt[commit_rd_1] = commit_prd_1;
    if (commit_en_2 && commit_rd_2 != '0) arch_nxt[commit_rd_2] = commit_prd_2;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_AREG; i++) begin
        spec_rat[i] <= PREG_W'(i);
        arch_rat[i] <= PREG_W'(i);
      end
      out_q   <= '0;
      out_vld <= '0;
    end else begin
      arch_rat <= arch_nxt;
      if (recover) begin
        spec_rat <= arch_nxt;
        out_vld  <= '0;
      end else if (accept) begin
        for (int l = 0; l < NUM_LANES; l++)
          if (need[l]) spec_rat[req[l].rd] <= ren[l].prd;
        out_q   <= ren;
        out_vld <= {in_valid_2, 1'b1};
      end else if (out_ready) begin
        out_vld <= '0;
      end
    end
  end

  free_list #(.PREG_W(PREG_W), .FL_DEPTH(FL_DEPTH)) u_free_list (
    .clk        (clk),
    .reset      (reset),
    .recover    (recover),
    .pop_cnt    (pop_cnt),
    .head_prd_1 (fl_head[0]),
    .head_prd_2 (fl_head[1]),
    .free_cnt   (free_cnt),
    .push_en    ({commit_en_2, commit_en_1}),
    .push_prd   ({commit_old_prd_2, commit_old_prd_1})
  );

  assign out_valid_1 = out_vld[0];
  assign out_valid_2 = out_vld[1];
  assign prs1_1      = out_q[0].prs1;
  assign prs2_1      = out_q[0].prs2;
  assign prd_1       = out_q[0].prd;
  assign old_prd_1   = out_q[0].old_prd;
  assign prs1_2      = out_q[1].prs1;
  assign prs2_2      = out_q[1].prs2;
  assign prd_2       = out_q[1].prd;
  assign old_prd_2   = out_q[1].old_prd;
endmodule

// File: tb/tb_rename_stage.sv
// Bench for rename_stage: directed scenarios then random traffic, all checked against
// a queue-based model (free queue + in-order ROB) evaluated with sequential rename rules.
module tb_rename_stage;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, in_valid_1, in_valid_2, rd_write_1, rd_write_2, out_ready, recover;
  logic [4:0] rs1_1, rs2_1, rd_1, rs1_2, rs2_2, rd_2, commit_rd_1, commit_rd_2;
  logic [5:0] commit_prd_1, commit_prd_2, commit_old_prd_1, commit_old_prd_2;
  logic       in_ready, out_valid_1, out_valid_2, commit_en_1, commit_en_2;
  logic [5:0] prs1_1, prs2_1, prd_1, old_prd_1, prs1_2, prs2_2, prd_2, old_prd_2;

  rename_stage dut (
    .clk(clk), .reset(reset), .in_valid_1(in_valid_1), .in_valid_2(in_valid_2),
    .rs1_1(rs1_1), .rs2_1(rs2_1), .rd_1(rd_1), .rs1_2(rs1_2), .rs2_2(rs2_2), .rd_2(rd_2),
    .rd_write_1(rd_write_1), .rd_write_2(rd_write_2), .in_ready(in_ready),
    .out_valid_1(out_valid_1), .out_valid_2(out_valid_2),
    .prs1_1(prs1_1), .prs2_1(prs2_1), .prd_1(prd_1), .old_prd_1(old_prd_1),
    .prs1_2(prs1_2), .prs2_2(prs2_2), .prd_2(prd_2), .old_prd_2(old_prd_2),
    .out_ready(out_ready), .commit_en_1(commit_en_1), .commit_en_2(commit_en_2),
    .commit_rd_1(commit_rd_1), .commit_rd_2(commit_rd_2),
    .commit_prd_1(commit_prd_1), .commit_prd_2(commit_prd_2),
    .commit_old_prd_1(commit_old_prd_1), .commit_old_prd_2(commit_old_prd_2),
    .recover(recover)
  );

  int n_vec = 0, n_err = 0;

  // Reference model
  typedef struct { int rd; int prd; int old; } rob_t;
  int   rat[32], arch[32];
  int   fl_q[$];
  rob_t rob_q[$];
  bit   m_ov1, m_ov2;
  int   m_out[8];

  function automatic void m_reset();
    for (int i = 0; i < 32; i++) begin rat[i] = i; arch[i] = i; end
    fl_q.delete();
    for (int i = 32; i < 64; i++) fl_q.push_back(i);
    rob_q.delete();
    m_ov1 = 0; m_ov2 = 0;
    for (int i = 0; i < 8; i++) m_out[i] = 0;
  endfunction

  function automatic int n_need();
    int n = 0;
    if (in_valid_1 && rd_write_1 && rd_1 != 0) n++;
    if (in_valid_2 && rd_write_2 && rd_2 != 0) n++;
    return n;
  endfunction

  function automatic bit m_ready();
    return !recover && (!m_ov1 || out_ready) && (fl_q.size() >= n_need());
  endfunction

  function automatic void m_edge();
    int   s[32];
    int   o[8];
    int   k;
    bit   acc;
    rob_t e;
    if (reset) begin m_reset(); return; end
    acc = in_valid_1 && m_ready();
    s = rat;
    k = 0;
    // Rename slot 1 then slot 2 against a running copy of the map.
    o[0] = s[rs1_1]; o[1] = s[rs2_1]; o[2] = 0; o[3] = 0;
    if (in_valid_1 && rd_write_1 && rd_1 != 0) begin
      o[2] = fl_q[k]; o[3] = s[rd_1]; s[rd_1] = o[2]; k++;
    end
    o[4] = s[rs1_2]; o[5] = s[rs2_2]; o[6] = 0; o[7] = 0;
    if (in_valid_2 && rd_write_2 && rd_2 != 0) begin
      o[6] = fl_q[k]; o[7] = s[rd_2]; s[rd_2] = o[6]; k++;
    end
    if (commit_en_1) begin
      arch[commit_rd_1] = commit_prd_1; fl_q.push_back(int'(commit_old_prd_1)); void'(rob_q.pop_front());
    end
    if (commit_en_2) begin
      arch[commit_rd_2] = commit_prd_2; fl_q.push_back(int'(commit_old_prd_2)); void'(rob_q.pop_front());
    end
    if (recover) begin
      rat = arch;
      for (int i = rob_q.size() - 1; i >= 0; i--) fl_q.push_front(rob_q[i].prd);
      rob_q.delete();
      m_ov1 = 0; m_ov2 = 0;
    end else if (acc) begin
      rat = s;
      for (int i = 0; i < k; i++) void'(fl_q.pop_front());
      if (o[2] != 0) begin e.rd = rd_1; e.prd = o[2]; e.old = o[3]; rob_q.push_back(e); end
      if (o[6] != 0) begin e.rd = rd_2; e.prd = o[6]; e.old = o[7]; rob_q.push_back(e); end
      m_out = o;
      m_ov1 = 1; m_ov2 = in_valid_2;
    end else if (out_ready) begin
      m_ov1 = 0; m_ov2 = 0;
    end
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
    chk("in_ready", 32'(in_ready), 32'(m_ready()));
    chk("out_valid_1", 32'(out_valid_1), 32'(m_ov1));
    chk("out_valid_2", 32'(out_valid_2), 32'(m_ov2));
    if (m_ov1) begin
      chk("prs1_1", 32'(prs1_1), m_out[0]);
      chk("prs2_1", 32'(prs2_1), m_out[1]);
      chk("prd_1", 32'(prd_1), m_out[2]);
      chk("old_prd_1", 32'(old_prd_1), m_out[3]);
    end
    if (m_ov2) begin
      chk("prs1_2", 32'(prs1_2), m_out[4]);
      chk("prs2_2", 32'(prs2_2), m_out[5]);
      chk("prd_2", 32'(prd_2), m_out[6]);
      chk("old_prd_2", 32'(old_prd_2), m_out[7]);
    end
    @(posedge clk);
    m_edge();
    #1;
  endtask

  task automatic idle();
    reset = 0; recover = 0; out_ready = 1;
    in_valid_1 = 0; in_valid_2 = 0; rd_write_1 = 0; rd_write_2 = 0;
    rs1_1 = 0; rs2_1 = 0; rd_1 = 0; rs1_2 = 0; rs2_2 = 0; rd_2 = 0;
    commit_en_1 = 0; commit_en_2 = 0; commit_rd_1 = 0; commit_rd_2 = 0;
    commit_prd_1 = 0; commit_prd_2 = 0; commit_old_prd_1 = 0; commit_old_prd_2 = 0;
  endtask

  task automatic grp(input logic v1, input logic [4:0] a1, input logic [4:0] b1, input logic [4:0] d1,
                     input logic w1, input logic v2, input logic [4:0] a2, input logic [4:0] b2,
                     input logic [4:0] d2, input logic w2);
    in_valid_1 = v1; rs1_1 = a1; rs2_1 = b1; rd_1 = d1; rd_write_1 = w1;
    in_valid_2 = v2; rs1_2 = a2; rs2_2 = b2; rd_2 = d2; rd_write_2 = w2;
  endtask

  task automatic commit_next(input int c);
    commit_en_1 = 0; commit_en_2 = 0;
    if (c >= 1) begin
      commit_en_1 = 1; commit_rd_1 = 5'(rob_q[0].rd);
      commit_prd_1 = 6'(rob_q[0].prd); commit_old_prd_1 = 6'(rob_q[0].old);
    end
    if (c >= 2) begin
      commit_en_2 = 1; commit_rd_2 = 5'(rob_q[1].rd);
      commit_prd_2 = 6'(rob_q[1].prd); commit_old_prd_2 = 6'(rob_q[1].old);
    end
  endtask

  task automatic do_reset();
    idle(); reset = 1; cyc(); cyc(); reset = 0;
  endtask

  initial begin
    int c, lim;
    m_reset();
    do_reset();
    cyc();
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_out_valid", 32'({out_valid_1, out_valid_2}), 0);
    chk("rst_prd", 32'({prs1_1, prs2_1, prd_1, old_prd_1}), 0);
    chk("rst_prd2", 32'({prs1_2, prs2_2, prd_2, old_prd_2}), 0);

    // First group with a source bypass.
    grp(1, 0, 0, 5, 1, 1, 5, 0, 6, 1); cyc(); idle();
    chk("a_prd_1", 32'(prd_1), 32);
    chk("a_prd_2", 32'(prd_2), 33);
    chk("a_prs1_2", 32'(prs1_2), 32);
    chk("a_old_1", 32'(old_prd_1), 5);
    chk("a_old_2", 32'(old_prd_2), 6);
    cyc();

    // Same destination in both slots, then read it back.
    grp(1, 0, 0, 7, 1, 1, 0, 0, 7, 1); cyc();
    chk("b_prd_1", 32'(prd_1), 34);
    chk("b_old_2", 32'(old_prd_2), 34);
    grp(1, 7, 0, 8, 1, 0, 0, 0, 0, 0); cyc();
    chk("b_prs1_1", 32'(prs1_1), 35);
    idle(); cyc();

    // Exhaust the free list, then free one register and reuse it.
    do_reset();
    for (int g = 0; g < 16; g++) begin
      grp(1, 0, 0, 5'(((2 * g + 2) % 31) + 1), 1, 1, 0, 0, 5'(((2 * g + 3) % 31) + 1), 1);
      cyc();
    end
    grp(1, 1, 2, 20, 1, 1, 3, 4, 21, 1);
    commit_next(1);
    #1 chk("full_in_ready", 32'(in_ready), 0);
    chk("full_commit_old", 32'(commit_old_prd_1), 3);
    cyc();
    commit_next(0);
    grp(1, 0, 0, 9, 1, 0, 0, 0, 0, 0); cyc();
    chk("recycle_prd", 32'(prd_1), 3);
    idle(); cyc();

    // Rename three groups, retire the first, flush.
    do_reset();
    grp(1, 0, 0, 1, 1, 1, 0, 0, 2, 1); cyc();
    grp(1, 0, 0, 3, 1, 1, 0, 0, 4, 1); cyc();
    grp(1, 0, 0, 5, 1, 1, 0, 0, 6, 1); cyc();
    idle(); commit_next(2); cyc();
    idle(); recover = 1; cyc();
    idle(); grp(1, 1, 0, 10, 1, 1, 3, 0, 11, 1); cyc();
    chk("rec_prd_1", 32'(prd_1), 34);
    chk("rec_prd_2", 32'(prd_2), 35);
    chk("rec_prs1_1", 32'(prs1_1), 32);
    chk("rec_prs1_2", 32'(prs1_2), 3);

    // Back-pressure holds the output and stalls the next group.
    grp(1, 0, 0, 12, 1, 1, 0, 0, 13, 1); cyc();
    out_ready = 0;
    grp(1, 0, 0, 14, 1, 1, 0, 0, 15, 1);
    #1 chk("stall_in_ready", 32'(in_ready), 0);
    for (int i = 0; i < 3; i++) cyc();
    chk("stall_prd_1", 32'(prd_1), 36);
    out_ready = 1; cyc();
    chk("stall_resume_prd", 32'(prd_1), 38);

    // Writing x0 allocates nothing.
    grp(1, 0, 0, 0, 1, 1, 0, 0, 16, 1); cyc();
    chk("x0_prd", 32'(prd_1), 0);
    chk("x0_old", 32'(old_prd_1), 0);
    chk("x0_next_prd", 32'(prd_2), 40);
    idle(); cyc();

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      idle();
      reset     = ($urandom_range(0, 99) == 0);
      recover   = ($urandom_range(0, 24) == 0);
      out_ready = ($urandom_range(0, 3) != 0);
      grp($urandom_range(0, 3) != 0, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 31)),
          5'($urandom_range(0, 7)), $urandom_range(0, 4) != 0, 1'b0,
          5'($urandom_range(0, 7)), 5'($urandom_range(0, 31)), 5'($urandom_range(0, 7)),
          $urandom_range(0, 4) != 0);
      in_valid_2 = in_valid_1 && ($urandom_range(0, 1) == 1);
      lim = (rob_q.size() < 2) ? rob_q.size() : 2;
      c = (fl_q.size() < 6) ? lim : int'($urandom_range(0, lim));
      commit_next(c);
      cyc();
    end
    idle(); cyc(); cyc();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
